// File: rtl/servo_pkg.sv
// Shared types, sizing helpers and board defaults for the servo sequencer.
// Channel indices name the cube-solver actuators.
package servo_pkg;

  localparam int DEF_PERIOD_CYCLES = 1000000;
  localparam int DEF_PULSE_MIN     = 50000;
  localparam int DEF_PULSE_STEP    = 25000;
  localparam int DEF_SETTLE_CYCLES = 50000000;
  localparam int DEF_CNT_W         = 26;

  localparam int CH_PETELECO = 0;
  localparam int CH_TAMPA    = 1;
  localparam int CH_BASE     = 2;

  function automatic int ch_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int pulse_width(input int pmin, input int step, input int pos);
    return pmin + pos * step;
  endfunction

endpackage

// File: rtl/servo_channel.sv
// One servo: position register, frame-aligned width latch, settle timer, pwm compare.
// Latency: position visible one cycle after accept, done SETTLE_CYCLES after accept.
// Backpressure: caller must only load while busy is low. SERVO_HOLD_RELEASE_EN adds torque release.
module servo_channel
  import servo_pkg::*;
#(
  parameter int POS_W         = 2,
  parameter int CNT_W         = DEF_CNT_W,
  parameter int PERIOD_CYCLES = DEF_PERIOD_CYCLES,
  parameter int PULSE_MIN     = DEF_PULSE_MIN,
  parameter int PULSE_STEP    = DEF_PULSE_STEP,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int RESET_POS     = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [CNT_W-1:0] frame_nxt,
  input  logic             frame_wrap,
  input  logic             load,
  input  logic [POS_W-1:0] load_pos,
  output logic [POS_W-1:0] pos_q,
  output logic             busy,
  output logic             done,
  output logic             pwm
`ifdef SERVO_HOLD_RELEASE_EN
  ,
  output logic             hold_released
`endif
);

  localparam int MAX_W = pulse_width(PULSE_MIN, PULSE_STEP, (1 << POS_W) - 1);
  localparam logic [CNT_W-1:0] RESET_W     = CNT_W'(pulse_width(PULSE_MIN, PULSE_STEP, RESET_POS));
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  if (MAX_W >= PERIOD_CYCLES) begin : g_width_check
    $error("servo_channel: widest pulse must be shorter than the frame");
  end

  logic [CNT_W-1:0] act_w;
  logic [CNT_W-1:0] act_w_nxt;
  logic [CNT_W-1:0] timer;
  logic             pwm_en_nxt;

  // The width only changes on the wrap edge, so a pulse is never cut short or stretched.
  assign act_w_nxt = frame_wrap ? CNT_W'(pulse_width(PULSE_MIN, PULSE_STEP, int'(pos_q))) : act_w;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pos_q <= POS_W'(RESET_POS);
      act_w <= RESET_W;
      timer <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      pwm   <= 1'b0;
    end else begin
      act_w <= act_w_nxt;
      pwm   <= pwm_en_nxt && (frame_nxt < act_w_nxt);
      done  <= busy && (timer == SETTLE_LAST);
      if (load) begin
        pos_q <= load_pos;
        busy  <= 1'b1;
        timer <= '0;
      end else if (busy) begin
        if (timer == SETTLE_LAST)
          busy <= 1'b0;
        else
          timer <= timer + 1'b1;
      end
    end
  end

`ifdef SERVO_HOLD_RELEASE_EN
  localparam int IDLE_W = CNT_W + 2;
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(4 * SETTLE_CYCLES - 1);

  logic [IDLE_W-1:0] idle_cnt;
  logic              armed;
  logic              muted;
  logic              rel_set;
  logic              muted_nxt;

  // Idle time counts only from a done; a fresh command unmutes at the next frame start.
  assign rel_set   = armed && !hold_released && !load && (idle_cnt == IDLE_LAST);
  assign muted_nxt = rel_set || (muted && !(frame_wrap && (load || !hold_released)));
  assign pwm_en_nxt = !muted_nxt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      idle_cnt      <= '0;
      armed         <= 1'b0;
      muted         <= 1'b0;
      hold_released <= 1'b0;
    end else begin
      muted <= muted_nxt;
      if (load) begin
        idle_cnt      <= '0;
        armed         <= 1'b0;
        hold_released <= 1'b0;
      end else if (done) begin
        idle_cnt <= '0;
        armed    <= 1'b1;
      end else if (armed && !hold_released) begin
        if (idle_cnt == IDLE_LAST)
          hold_released <= 1'b1;
        else
          idle_cnt <= idle_cnt + 1'b1;
      end
    end
  end
`else
  assign pwm_en_nxt = 1'b1;
`endif

endmodule

// File: rtl/servo_sequencer.sv
// Multi-channel servo manager: shared PWM frame counter, command decode, per-channel settle timers.
// Latency: accept to pos_q one cycle, accept to done SETTLE_CYCLES; new width from next frame.
// Backpressure: cmd_ready drops while the addressed channel is busy. Option: SERVO_HOLD_RELEASE_EN.
module servo_sequencer
  import servo_pkg::*;
#(
  parameter int N_CH          = 3,
  parameter int POS_W         = 2,
  parameter int PERIOD_CYCLES = DEF_PERIOD_CYCLES,
  parameter int PULSE_MIN     = DEF_PULSE_MIN,
  parameter int PULSE_STEP    = DEF_PULSE_STEP,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int RESET_POS     = 0,
  parameter int CNT_W         = DEF_CNT_W,
  localparam int CH_W         = ch_w(N_CH)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [CH_W-1:0]       cmd_ch,
  input  logic [POS_W-1:0]      cmd_pos,
  output logic                  cmd_err,
  output logic [N_CH-1:0]       pwm,
  output logic [N_CH-1:0]       busy,
  output logic [N_CH-1:0]       done,
  output logic [N_CH*POS_W-1:0] pos_q
`ifdef SERVO_HOLD_RELEASE_EN
  ,
  output logic [N_CH-1:0]       hold_released
`endif
);

  localparam int NX = 1 << CH_W;
  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(PERIOD_CYCLES - 1);

  if ((longint'(PERIOD_CYCLES) > (longint'(1) << CNT_W)) ||
      (longint'(SETTLE_CYCLES) > (longint'(1) << CNT_W))) begin : g_cnt_check
    $error("servo_sequencer: CNT_W too narrow for frame or settle count");
  end

  logic [CNT_W-1:0] frame_cnt;
  logic [CNT_W-1:0] frame_nxt;
  logic             frame_wrap;
  logic [NX-1:0]    busy_ext;
  logic             ch_ok;
  logic             accept;

  assign frame_wrap = (frame_cnt == FRAME_LAST);
  assign frame_nxt  = frame_wrap ? '0 : frame_cnt + 1'b1;

  // Unused channel codes read as idle so a bad index is always accepted and flagged.
  assign busy_ext  = NX'(busy);
  assign ch_ok     = int'(cmd_ch) < N_CH;
  assign cmd_ready = ch_ok ? !busy_ext[cmd_ch] : 1'b1;
  assign accept    = cmd_valid && cmd_ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      frame_cnt <= '0;
      cmd_err   <= 1'b0;
    end else begin
      frame_cnt <= frame_nxt;
      cmd_err   <= accept && !ch_ok;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    servo_channel #(
      .POS_W         (POS_W),
      .CNT_W         (CNT_W),
      .PERIOD_CYCLES (PERIOD_CYCLES),
      .PULSE_MIN     (PULSE_MIN),
      .PULSE_STEP    (PULSE_STEP),
      .SETTLE_CYCLES (SETTLE_CYCLES),
      .RESET_POS     (RESET_POS)
    ) u_ch (
      .clock         (clock),
      .reset         (reset),
      .frame_nxt     (frame_nxt),
      .frame_wrap    (frame_wrap),
      .load          (accept && ch_ok && (cmd_ch == CH_W'(i))),
      .load_pos      (cmd_pos),
      .pos_q         (pos_q[i*POS_W +: POS_W]),
      .busy          (busy[i]),
      .done          (done[i]),
      .pwm           (pwm[i])
`ifdef SERVO_HOLD_RELEASE_EN
      ,
      .hold_released (hold_released[i])
`endif
    );
  end

endmodule

// File: doc/servo_sequencer.md
Name: servo_sequencer

Overview:
Parametrised multi-channel servo manager (peteleco, tampa, base and future actuators). It accepts position commands over a valid/ready handshake and drives one PWM output per channel from a shared 20 ms frame counter. Each channel runs an independent settle timer with per-channel busy/done status, so the cube-solver control FSM can overlap moves on different servos. It replaces the fixed three-servo datapath with its hard-wired fixed-duration counters.

Parameters:
N_CH, 3, number of servo channels (1..8)
POS_W, 2, position code width per channel
PERIOD_CYCLES, 1000000, PWM frame length in clocks (20 ms at 50 MHz)
PULSE_MIN, 50000, pulse width for position 0 (1 ms)
PULSE_STEP, 25000, added pulse width per position LSB
SETTLE_CYCLES, 50000000, clocks from command accept to done
RESET_POS, 0, position code loaded into every channel at reset
CNT_W, 26, width of frame and settle counters; must hold PERIOD_CYCLES and SETTLE_CYCLES

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
cmd_valid  in  1  command present
cmd_ready  out  1  command can be accepted this cycle
cmd_ch  in  CH_W = max(1, clog2(N_CH))  target channel index
cmd_pos  in  POS_W  target position code
cmd_err  out  1  one-cycle pulse when a command names a channel index >= N_CH
pwm  out  N_CH  servo control outputs
busy  out  N_CH  channel settle timer running
done  out  N_CH  one-cycle pulse when a channel's settle time expires
pos_q  out  N_CH*POS_W  current position code per channel; channel i at bits [i*POS_W +: POS_W]

Behaviour:
- Reset (async, reset=0): frame counter=0, all settle timers=0, pos_q=RESET_POS on every channel, active widths from RESET_POS, pwm=0, busy=0, done=0, cmd_err=0. Reset asserted mid-move aborts the timer with no done pulse.
- Frame counter: free-running 0..PERIOD_CYCLES-1, wraps to 0.
- Pulse width: width_i = PULSE_MIN + pos_i*PULSE_STEP, computed at CNT_W bits. Elaboration fails if the maximum width >= PERIOD_CYCLES.
- pwm_i is registered: pwm_i = 1 while frame counter < active_width_i.
- Width update: active_width_i reloads from pos_q only on the cycle the frame counter wraps to 0. This means no truncated or stretched pulses.
- cmd_ready is combinational: cmd_ready = !busy[cmd_ch] when cmd_ch < N_CH, else 1.
- Accept happens when cmd_valid && cmd_ready. On the next edge:
  - pos_q[ch] <= cmd_pos.
  - busy[ch] <= 1.
  - Timer loads 0.
- Settle: the timer increments each cycle while busy. When the timer reaches SETTLE_CYCLES-1, the next edge sets busy=0 and pulses done=1 for exactly 1 cycle. Latency from accept edge to done = SETTLE_CYCLES cycles.
- Same-position command: handled as a normal move (full settle, done pulse). The FSM relies on uniform timing.
- Invalid channel (cmd_ch >= N_CH): accepted, no state change, cmd_err=1 for one cycle.
- Simultaneous events:
  - A command to channel X in the cycle X's done is high is legal (busy already 0). X restarts; done stays a single pulse.
  - Commands to different channels are serialised by the single command port; timers run concurrently.
  - A frame wrap coinciding with accept uses the old pos_q; the new width applies from the following frame.

Optional Feature:
SERVO_HOLD_RELEASE_EN: when defined, each channel keeps an idle counter. After 4*SETTLE_CYCLES with busy=0 since its last done, that channel's pwm is forced to 0 (torque release, less jitter). Any accepted command to the channel clears the idle counter and re-enables pwm at the next frame wrap. A hold_released output (N_CH bits) is added. When undefined, pwm runs continuously, no idle counters are built, and the hold_released port is absent.

Decomposition:
- Package servo_pkg:
  - CH_W function (max(1, clog2)).
  - Width function (PULSE_MIN + pos*PULSE_STEP).
  - Default timing constants for the 50 MHz board.
  - Channel index constants for PETELECO=0, TAMPA=1, BASE=2.
- Sub-module servo_channel, generated N_CH times: position register, active-width latch, settle timer, busy/done logic, pwm compare (plus the idle counter under the macro).
- Top level holds the frame counter, command decode/ready mux and cmd_err.

Test Plan:
(Run with PERIOD_CYCLES=100, PULSE_MIN=10, PULSE_STEP=5, SETTLE_CYCLES=20.)
- Reset: hold reset=0 for 3 cycles, release -> pwm high for 10 of every 100 cycles on all channels, busy=0, pos_q=0.
- Single move: cmd ch1 pos3 accepted mid-frame -> pos_q[1]=3 next cycle. busy[1] high for 20 cycles, then done[1] one-cycle pulse. pwm[1] width is 25 starting exactly at the next frame wrap.
- Backpressure: second cmd to ch1 while busy -> cmd_ready=0, no state change. Concurrent cmd to ch2 -> accepted and both timers run, with done[2] 20 cycles after its accept.
- Boundaries:
  - cmd to ch1 in the cycle done[1]=1 -> accepted, busy[1]=1 next cycle, done[1] is a single pulse.
  - cmd_ch=3 with N_CH=3 -> cmd_err pulse, no state change.
- Reset mid-move: reset=0 at timer=10 -> busy=0, no done, pos_q=RESET_POS, pwm=0 immediately.
- SERVO_HOLD_RELEASE_EN: idle 80 cycles after done -> pwm=0 and hold_released=1. New cmd -> pwm resumes at the next frame wrap.
